debug_control: RTL

Debug-unit sequencer that sits between the host command channel (UART receiver/transmitter byte streams) and the pipelined MIPS core. It decodes one-byte commands and drives the core's `activo` (run enable) and soft-reset (`inicio`) inputs for continuous-run, single-step and reset. It takes over the data-memory debug port (`mem_in`, `mem_write_in`, `add_in`) to stream memory words back to the host, optionally preceded by an executed-cycle count.

---
 rtl/debug_pkg.sv | 30 +++
 rtl/debug_control_if.sv | 28 ++
 rtl/byte_serializer.sv | 51 +++++
 rtl/debug_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared encodings for the debug-unit sequencer: host command bytes and the
// sequencer state enum. The host-side model and the bench use the same values.
// Optional feature macro used by the block: DEBUG_CYCLE_COUNT_EN (see
// debug_control.sv).
// -----------------------------------------------------------------------------
package debug_pkg;

    localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
    localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
    localparam logic [7:0] CMD_RST  = 8'h72;  // 'r'
    localparam logic [7:0] CMD_DUMP = 8'h6D;  // 'm'
    localparam logic [7:0] CMD_HALT = 8'h70;  // 'p'

    // ST_CNT_SEND is only reachable when DEBUG_CYCLE_COUNT_EN is defined.
    // It keeps its encoding in both builds so host tools can decode the state
    // without knowing how the block was built.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP      = 3'd2,
        ST_RST       = 3'd3,
        ST_CNT_SEND  = 3'd4,
        ST_DUMP_ADDR = 3'd5,
        ST_DUMP_WAIT = 3'd6,
        ST_DUMP_SEND = 3'd7
    } state_t;

endpackage

// File: rtl/debug_control_if.sv
// -----------------------------------------------------------------------------
// debug_control_if
// Byte-stream channels between the host UART and the debug sequencer.
//   cmd_valid/cmd_data/cmd_ready : command bytes from UART RX to the block
//   tx_valid/tx_data/tx_ready    : response bytes from the block to UART TX
// Handshake: a byte moves on a rising edge where valid && ready are both 1.
// A source holding valid keeps its data stable until that transfer; ready may
// be asserted independently of valid and does not depend on valid.
// master = host side, slave = debug_control.
// -----------------------------------------------------------------------------
interface debug_control_if;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output cmd_valid, cmd_data, tx_ready,
        input  cmd_ready, tx_valid, tx_data
    );

    modport slave (
        input  cmd_valid, cmd_data, tx_ready,
        output cmd_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
// Loads a 32-bit word and emits it as 4 bytes, LSB first, over valid/ready.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load, word  : load a new word (only issued while idle)
//   tx_valid    : registered byte-valid
//   tx_data     : registered byte
//   tx_ready    : downstream accepts the byte
//   done        : one-cycle pulse on the edge that moves the 4th byte
// -----------------------------------------------------------------------------
module byte_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done
);

    logic [23:0] rest_q;   // bytes still to be presented, next one in [7:0]
    logic [1:0]  cnt_q;    // index of the byte currently on tx_data

    // Combinational so the owner can move on in the same edge as the last byte.
    assign done = tx_valid && tx_ready && (cnt_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            rest_q   <= 24'h0;
            cnt_q    <= 2'd0;
        end else if (load) begin
            tx_valid <= 1'b1;
            tx_data  <= word[7:0];
            rest_q   <= word[31:8];
            cnt_q    <= 2'd0;
        end else if (tx_valid && tx_ready) begin
            if (cnt_q == 2'd3) begin
                tx_valid <= 1'b0;
            end else begin
                tx_data <= rest_q[7:0];
                rest_q  <= {8'h00, rest_q[23:8]};
                cnt_q   <= cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/debug_control.sv
// -----------------------------------------------------------------------------
// debug_control
// Debug-unit sequencer between the host UART byte streams and the pipelined
// MIPS core. Decodes one-byte commands: run ('c'), step ('s'), reset ('r'),
// dump ('m'), halt ('p', only while running). Drives the core run enable and
// soft reset, and takes over the data-memory debug port to stream memory
// words back to the host, 4 bytes per word, LSB first.
//
// Optional feature: define DEBUG_CYCLE_COUNT_EN to add a saturating 32-bit
// executed-cycle counter that 'm' sends ahead of the memory words.
//
// Ports:
//   clk            : clock
//   inicio         : asynchronous active-high reset
//   bus            : command (in) and response (out) byte channels
//   finalW         : core end-of-program flag
//   ReadDataM      : data-memory read data (one-cycle read latency)
//   activo_o       : core run enable
//   inicio_o       : core soft reset
//   mem_in_o       : selects add_in_o as data-memory address
//   mem_write_in_o : forces data-memory write enables to zero
//   add_in_o       : debug memory word address
//   dbg_state      : current sequencer state
// All outputs are registered.
// -----------------------------------------------------------------------------
module debug_control
    import debug_pkg::*;
#(
    parameter int DUMP_WORDS = 16,
    parameter int RST_CYCLES = 2,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              inicio,
    debug_control_if.slave    bus,
    input  logic              finalW,
    input  logic [31:0]       ReadDataM,
    output logic              activo_o,
    output logic              inicio_o,
    output logic              mem_in_o,
    output logic              mem_write_in_o,
    output logic [ADDR_W-1:0] add_in_o,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       rst_cnt_q, rst_cnt_d;
    logic              cmd_ready_q;
    logic              activo_q;
    logic              inicio_q;
    logic              mem_q;
    logic              accept;
    logic              ser_load;
    logic [31:0]       ser_word;
    logic              ser_done;

    assign accept = bus.cmd_valid && cmd_ready_q;

`ifdef DEBUG_CYCLE_COUNT_EN
    logic [31:0] cycle_cnt_q;

    // Counts cycles the core actually ran; a soft reset clears it.
    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) begin
            cycle_cnt_q <= 32'h0;
        end else if (state_q == ST_RST) begin
            cycle_cnt_q <= 32'h0;
        end else if (activo_q && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rst_cnt_d = rst_cnt_q;
        ser_load  = 1'b0;
        ser_word  = ReadDataM;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.cmd_data)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_RST: begin
                            state_d   = ST_RST;
                            rst_cnt_d = 16'd0;
                        end
                        CMD_DUMP: begin
                            idx_d = '0;
`ifdef DEBUG_CYCLE_COUNT_EN
                            // Counter value is latched here, at accept.
                            state_d  = ST_CNT_SEND;
                            ser_load = 1'b1;
                            ser_word = cycle_cnt_q;
`else
                            state_d = ST_DUMP_ADDR;
`endif
                        end
                        default: ;  // unknown byte consumed and ignored
                    endcase
                end
            end
            ST_RUN: begin
                // Halt and end-of-program together still mean one return.
                if (finalW || (accept && (bus.cmd_data == CMD_HALT))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: state_d = ST_IDLE;
            ST_RST: begin
                if (rst_cnt_q == 16'(RST_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 16'd1;
                end
            end
`ifdef DEBUG_CYCLE_COUNT_EN
            ST_CNT_SEND: begin
                if (ser_done) begin
                    state_d = ST_DUMP_ADDR;
                end
            end
`endif
            ST_DUMP_ADDR: state_d = ST_DUMP_WAIT;
            ST_DUMP_WAIT: begin
                // Read data for add_in_o is valid now; capture it on this edge.
                ser_load = 1'b1;
                ser_word = ReadDataM;
                state_d  = ST_DUMP_SEND;
            end
            ST_DUMP_SEND: begin
                if (ser_done) begin
                    if (idx_q == ADDR_W'(DUMP_WORDS - 1)) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_DUMP_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs. Outputs are computed from state_d so they
    // line up with the state they belong to, one edge after the cause.
    always_ff @(posedge clk or posedge inicio) begin
        if (inicio) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            rst_cnt_q   <= 16'd0;
            cmd_ready_q <= 1'b0;
            activo_q    <= 1'b0;
            inicio_q    <= 1'b0;
            mem_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rst_cnt_q   <= rst_cnt_d;
            cmd_ready_q <= (state_d == ST_IDLE) || (state_d == ST_RUN);
            activo_q    <= (state_d == ST_RUN) || (state_d == ST_STEP);
            inicio_q    <= (state_d == ST_RST);
            mem_q       <= (state_d == ST_DUMP_ADDR) || (state_d == ST_DUMP_WAIT) ||
                           (state_d == ST_DUMP_SEND);
        end
    end

    byte_serializer u_ser (
        .clk      (clk),
        .rst      (inicio),
        .load     (ser_load),
        .word     (ser_word),
        .tx_valid (bus.tx_valid),
        .tx_data  (bus.tx_data),
        .tx_ready (bus.tx_ready),
        .done     (ser_done)
    );

    assign bus.cmd_ready  = cmd_ready_q;
    assign activo_o       = activo_q;
    assign inicio_o       = inicio_q;
    assign mem_in_o       = mem_q;
    assign mem_write_in_o = mem_q;
    assign add_in_o       = idx_q;
    assign dbg_state      = state_q;

endmodule
